// File: rtl/dm_responder.sv
// Data-memory responder for the core's DM_* port: a word array cleared by a sweep after reset,
// a loader port for preloading it, and saturating read/write activity counters.
module dm_responder #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  DM_enable,
  input  logic                  DM_read,
  input  logic                  DM_write,
  input  logic [ADDR_WIDTH-1:0] DM_address,
  input  logic [DATA_WIDTH-1:0] DM_in,
  output logic [DATA_WIDTH-1:0] DM_out,
  input  logic                  load_valid,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  mem_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clear_ptr_q, clear_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [CNT_WIDTH-1:0]  rd_count_q, wr_count_q;
  logic                  core_rd, core_wr, load_acc;
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    if (state_q == StClear) begin
      clear_ptr_d = clear_ptr_q + 1'b1;
      if (&clear_ptr_q) state_d = StIdle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StClear;
      clear_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
    end
  end

  assign mem_ready  = (state_q == StIdle);
  assign core_rd    = mem_ready & DM_enable & DM_read;
  assign core_wr    = mem_ready & DM_enable & DM_write;
  // A core store owns the single write port, so the loader is stalled for that cycle.
  assign load_ready = mem_ready & ~(DM_enable & DM_write);
  assign load_acc   = load_valid & load_ready;

  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem_q[clear_ptr_q] <= '0;
    end else if (core_wr) begin
      mem_q[DM_address] <= DM_in;
    end else if (load_acc) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // Write-first: a store in the same cycle forwards its data to the read.
  assign rd_word = core_wr ? DM_in : mem_q[DM_address];

  if (READ_LATENCY == 0) begin : g_lat0
    assign DM_out = core_rd ? rd_word : '0;
  end else begin : g_lat1
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
      end else if (core_rd) begin
        dout_q <= rd_word;
      end
    end
    assign DM_out = dout_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      if (core_rd && !(&rd_count_q)) rd_count_q <= rd_count_q + 1'b1;
      if (core_wr && !(&wr_count_q)) wr_count_q <= wr_count_q + 1'b1;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_dm_responder.sv
// Randomized bench for dm_responder: a zero-latency instance with 4-bit counters and a
// one-cycle-latency instance share stimulus and are checked against a word-level model.
module tb_dm_responder;

  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, rd, wr, lv;
  logic [AW-1:0] addr, la;
  logic [31:0]   din, ld;

  logic [31:0]   out0, out1;
  logic          lr0, lr1, mr0, mr1;
  logic [3:0]    rc0, wc0;
  logic [15:0]   rc1, wc1;

  always #5 clk = ~clk;

  dm_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .READ_LATENCY(0), .CNT_WIDTH(4)) u_lat0 (
    .clk(clk), .rst(rst), .DM_enable(en), .DM_read(rd), .DM_write(wr), .DM_address(addr),
    .DM_in(din), .DM_out(out0), .load_valid(lv), .load_addr(la), .load_data(ld),
    .load_ready(lr0), .mem_ready(mr0), .rd_count(rc0), .wr_count(wc0)
  );

  dm_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .READ_LATENCY(1), .CNT_WIDTH(16)) u_lat1 (
    .clk(clk), .rst(rst), .DM_enable(en), .DM_read(rd), .DM_write(wr), .DM_address(addr),
    .DM_in(din), .DM_out(out1), .load_valid(lv), .load_addr(la), .load_data(ld),
    .load_ready(lr1), .mem_ready(mr1), .rd_count(rc1), .wr_count(wc1)
  );

  // Reference model: memory image, cycles spent sweeping, raw access counts.
  logic [31:0] ref_mem [DEPTH];
  bit          m_ready;
  int          m_sweep;
  int          m_rd, m_wr;
  logic [31:0] m_out1;
  bit          load_taken;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_checks++;
    if (obs !== expd) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, expd, $time);
    end
  endtask

  function automatic logic [31:0] sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic model_reset();
    foreach (ref_mem[i]) ref_mem[i] = '0;
    m_ready = 0;
    m_sweep = 0;
    m_rd    = 0;
    m_wr    = 0;
    m_out1  = '0;
  endtask

  // Check outputs mid-cycle, then advance the model on the rising edge.
  task automatic cycle();
    logic [31:0] e0, rdw;
    bit          lrdy;
    @(negedge clk);
    lrdy = m_ready && !(en && wr);
    rdw  = wr ? din : ref_mem[addr];
    e0   = (m_ready && en && rd) ? rdw : 32'h0;
    check("mem_ready0", {31'b0, mr0}, {31'b0, m_ready});
    check("mem_ready1", {31'b0, mr1}, {31'b0, m_ready});
    check("load_ready0", {31'b0, lr0}, {31'b0, lrdy});
    check("load_ready1", {31'b0, lr1}, {31'b0, lrdy});
    check("dm_out_lat0", out0, e0);
    check("dm_out_lat1", out1, m_out1);
    check("rd_count0", {28'b0, rc0}, sat(m_rd, 15));
    check("wr_count0", {28'b0, wc0}, sat(m_wr, 15));
    check("rd_count1", {16'b0, rc1}, sat(m_rd, 65535));
    check("wr_count1", {16'b0, wc1}, sat(m_wr, 65535));
    @(posedge clk);
    load_taken = 0;
    if (!rst) begin
      if (!m_ready) begin
        m_sweep++;
        if (m_sweep == DEPTH) m_ready = 1;
      end else if (en) begin
        if (rd) begin
          m_out1 = rdw;
          m_rd++;
        end
        if (wr) begin
          ref_mem[addr] = din;
          m_wr++;
        end else if (lv) begin
          ref_mem[la] = ld;
          load_taken  = 1;
        end
      end else if (lv) begin
        ref_mem[la] = ld;
        load_taken  = 1;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    en = 0; rd = 0; wr = 0; addr = '0; din = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_ready0", {31'b0, mr0}, 32'h0);
    check("async_rst_ready1", {31'b0, mr1}, 32'h0);
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  task automatic sweep(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    lv = 0; la = '0; ld = '0;
    load_taken = 0;
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;
    sweep(DEPTH + 1);
    check("ready_after_sweep", {31'b0, mr0 & mr1}, 32'h1);

    // Cleared contents at scattered addresses.
    for (int i = 0; i < 8; i++) begin
      en = 1; rd = 1; wr = 0; addr = AW'($urandom_range(0, DEPTH - 1));
      cycle();
    end

    // Counter saturation on the 4-bit instance.
    repeat (20) begin
      en = 1; rd = 1; wr = 0; addr = AW'($urandom_range(0, 63));
      cycle();
    end

    // Loader stalled by a same-cycle core store, accepted the next cycle.
    en = 1; rd = 0; wr = 1; addr = 12'h006; din = 32'hCAFE_F00D;
    lv = 1; la = 12'h005; ld = 32'hDEAD_BEEF;
    cycle();
    idle_inputs();
    cycle();
    lv = 0;
    en = 1; rd = 1; addr = 12'h005; cycle();
    addr = 12'h006; cycle();
    idle_inputs(); cycle();

    // Write-first read, then held registered output.
    en = 1; rd = 1; wr = 1; addr = 12'h010; din = 32'h1234_5678;
    cycle();
    en = 1; rd = 1; wr = 0; addr = 12'h005;
    cycle();
    idle_inputs();
    repeat (3) cycle();
    en = 0; rd = 1; addr = 12'h010;
    cycle();

    // Read and loader write to the same word: old data first, new data next cycle.
    en = 1; rd = 1; wr = 0; addr = 12'h005; lv = 1; la = 12'h005; ld = 32'h0BAD_F00D;
    cycle();
    lv = 0;
    cycle();
    cycle();

    for (int i = 0; i < 3000; i++) begin
      en   = ($urandom_range(0, 7) != 0);
      rd   = 1'($urandom_range(0, 1));
      wr   = ($urandom_range(0, 3) == 0);
      addr = AW'($urandom_range(0, 15));
      din  = $urandom;
      if (!lv || load_taken) begin
        lv = 1'($urandom_range(0, 1));
        la = AW'($urandom_range(0, 15));
        ld = $urandom;
      end
      cycle();
    end

    // Reset with a loader beat pending drops it; the sweep clears the array again.
    idle_inputs();
    en = 1; wr = 1; addr = 12'h00A; din = 32'h5555_AAAA; lv = 1; la = 12'h00B; ld = 32'h7777_1111;
    do_reset();
    lv = 0;
    idle_inputs();
    sweep(100);
    do_reset();
    sweep(DEPTH + 1);
    for (int a = 0; a < 16; a++) begin
      en = 1; rd = 1; wr = 0; addr = AW'(a);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
